// File: rtl/alu_share_if.sv
// Handshake/bus bundle between two ALU clients and the shared ALU arbiter.
// With ALU_FLAGS_EN defined the bundle also carries the zero/carry flags.
interface alu_share_if #(
   parameter int WIDTH = 3
);
   logic             req0;
   logic [1:0]       op0;
   logic [WIDTH-1:0] a0;
   logic [WIDTH-1:0] b0;
   logic             req1;
   logic [1:0]       op1;
   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] b1;
   logic             ack0;
   logic             ack1;
   logic             gnt0;
   logic             gnt1;
   logic             done0;
   logic             done1;
   logic [WIDTH-1:0] result;
   logic             busy;
`ifdef ALU_FLAGS_EN
   logic             zero;
   logic             carry;

   modport master (
      output req0, op0, a0, b0, req1, op1, a1, b1, ack0, ack1,
      input  gnt0, gnt1, done0, done1, result, busy, zero, carry
   );
   modport slave (
      input  req0, op0, a0, b0, req1, op1, a1, b1, ack0, ack1,
      output gnt0, gnt1, done0, done1, result, busy, zero, carry
   );
`else
   modport master (
      output req0, op0, a0, b0, req1, op1, a1, b1, ack0, ack1,
      input  gnt0, gnt1, done0, done1, result, busy
   );
   modport slave (
      input  req0, op0, a0, b0, req1, op1, a1, b1, ack0, ack1,
      output gnt0, gnt1, done0, done1, result, busy
   );
`endif
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one add/sub/and/shr ALU between two requesters.
// Optional macro ALU_FLAGS_EN adds registered zero/carry outputs.
module alu_share_arbiter #(
   parameter int WIDTH = 3
) (
   input logic       clk,
   input logic       rst_n,
   alu_share_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state_reg, state_next;
   logic             ptr_reg, ptr_next;
   logic             owner_reg, owner_next;
   logic [1:0]       op_reg, op_next;
   logic [WIDTH-1:0] a_reg, a_next;
   logic [WIDTH-1:0] b_reg, b_next;
   logic [WIDTH-1:0] result_reg, result_next;
   logic             gnt0_reg, gnt0_next;
   logic             gnt1_reg, gnt1_next;
   logic             done0_reg, done0_next;
   logic             done1_reg, done1_next;
   logic             busy_reg, busy_next;
   logic             win_w;
   logic [WIDTH-1:0] alu_y;

   // Pointer only matters on a tie; a lone requester always wins.
   assign win_w = (bus.req0 && bus.req1) ? ptr_reg : bus.req1;

`ifdef ALU_FLAGS_EN
   logic             zero_reg, zero_next;
   logic             carry_reg, carry_next;
   logic             alu_c;
   logic [WIDTH:0]   sum_w, diff_w;

   assign sum_w  = {1'b0, a_reg} + {1'b0, b_reg};
   assign diff_w = {1'b0, a_reg} + {1'b0, ~b_reg} + {{WIDTH{1'b0}}, 1'b1};
   assign alu_c  = (op_reg == 2'd0) ? sum_w[WIDTH] :
                   (op_reg == 2'd1) ? diff_w[WIDTH] : 1'b0;
   assign bus.zero  = zero_reg;
   assign bus.carry = carry_reg;
`else
   logic [WIDTH-1:0] sum_w, diff_w;

   assign sum_w  = a_reg + b_reg;
   assign diff_w = a_reg + ~b_reg + {{(WIDTH-1){1'b0}}, 1'b1};
`endif

   always_comb begin
      alu_y = '0;
      case (op_reg)
         2'd0:    alu_y = sum_w[WIDTH-1:0];
         2'd1:    alu_y = diff_w[WIDTH-1:0];
         2'd2:    alu_y = a_reg & b_reg;
         default: alu_y = {1'b0, a_reg[WIDTH-1:1]};
      endcase
   end

   always_comb begin
      state_next  = state_reg;
      ptr_next    = ptr_reg;
      owner_next  = owner_reg;
      op_next     = op_reg;
      a_next      = a_reg;
      b_next      = b_reg;
      result_next = result_reg;
      gnt0_next   = 1'b0;
      gnt1_next   = 1'b0;
      done0_next  = done0_reg;
      done1_next  = done1_reg;
`ifdef ALU_FLAGS_EN
      zero_next   = zero_reg;
      carry_next  = carry_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               owner_next = win_w;
               op_next    = win_w ? bus.op1 : bus.op0;
               a_next     = win_w ? bus.a1  : bus.a0;
               b_next     = win_w ? bus.b1  : bus.b0;
               gnt0_next  = !win_w;
               gnt1_next  = win_w;
               state_next = EXEC;
            end
         end
         EXEC: begin
            result_next = alu_y;
`ifdef ALU_FLAGS_EN
            zero_next   = (alu_y == '0);
            carry_next  = alu_c;
`endif
            state_next  = RESP;
         end
         RESP: begin
            // First RESP cycle raises done; ack is honoured only once done is visible.
            if (!(done0_reg || done1_reg)) begin
               done0_next = !owner_reg;
               done1_next = owner_reg;
            end else if (owner_reg ? bus.ack1 : bus.ack0) begin
               done0_next = 1'b0;
               done1_next = 1'b0;
               ptr_next   = !owner_reg;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         ptr_reg    <= 1'b0;
         owner_reg  <= 1'b0;
         op_reg     <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         result_reg <= '0;
         gnt0_reg   <= 1'b0;
         gnt1_reg   <= 1'b0;
         done0_reg  <= 1'b0;
         done1_reg  <= 1'b0;
         busy_reg   <= 1'b0;
`ifdef ALU_FLAGS_EN
         zero_reg   <= 1'b0;
         carry_reg  <= 1'b0;
`endif
      end else begin
         state_reg  <= state_next;
         ptr_reg    <= ptr_next;
         owner_reg  <= owner_next;
         op_reg     <= op_next;
         a_reg      <= a_next;
         b_reg      <= b_next;
         result_reg <= result_next;
         gnt0_reg   <= gnt0_next;
         gnt1_reg   <= gnt1_next;
         done0_reg  <= done0_next;
         done1_reg  <= done1_next;
         busy_reg   <= busy_next;
`ifdef ALU_FLAGS_EN
         zero_reg   <= zero_next;
         carry_reg  <= carry_next;
`endif
      end
   end

   assign bus.gnt0   = gnt0_reg;
   assign bus.gnt1   = gnt1_reg;
   assign bus.done0  = done0_reg;
   assign bus.done1  = done1_reg;
   assign bus.result = result_reg;
   assign bus.busy   = busy_reg;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus random traffic checked
// against an arithmetic reference model of the ALU and round-robin rules.
module tb_alu_share_arbiter;
   localparam int W   = 3;
   localparam int MOD = 1 << W;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   favour = 0;

   always #5 clk = ~clk;

   alu_share_if #(.WIDTH(W)) bus_if();

   alu_share_arbiter #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus_if)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_result(input int op, input int a, input int b);
      case (op)
         0:       return (a + b) % MOD;
         1:       return (a - b + MOD) % MOD;
         2:       return a & b;
         default: return a / 2;
      endcase
   endfunction

   function automatic int ref_carry(input int op, input int a, input int b);
      if (op == 0) return (a + b >= MOD) ? 1 : 0;
      if (op == 1) return (a >= b) ? 1 : 0;
      return 0;
   endfunction

   // mode 0: normal ack; mode 1: glitch the other ack, then reset mid-RESP
   task automatic txn(input bit r0, input bit r1,
                      input int op0, input int a0, input int b0,
                      input int op1, input int a1, input int b1,
                      input bit hold, input int mode);
      int w, lat, eop, ea, eb, er;
      bus_if.req0 = r0; bus_if.op0 = 2'(op0); bus_if.a0 = 3'(a0); bus_if.b0 = 3'(b0);
      bus_if.req1 = r1; bus_if.op1 = 2'(op1); bus_if.a1 = 3'(a1); bus_if.b1 = 3'(b1);
      w   = (r0 && r1) ? favour : (r1 ? 1 : 0);
      eop = w ? op1 : op0;
      ea  = w ? a1 : a0;
      eb  = w ? b1 : b0;
      er  = ref_result(eop, ea, eb);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!(bus_if.gnt0 || bus_if.gnt1) && lat < 8);
      chk("gnt_latency", 32'(lat), 32'd1);
      chk("gnt0", 32'(bus_if.gnt0), 32'(w == 0));
      chk("gnt1", 32'(bus_if.gnt1), 32'(w == 1));
      // Disturb every input after the grant; the latched copy must be used.
      bus_if.op0 = 2'($urandom_range(0, 3)); bus_if.a0 = 3'($urandom_range(0, 7));
      bus_if.b0  = 3'($urandom_range(0, 7));
      bus_if.op1 = 2'($urandom_range(0, 3)); bus_if.a1 = 3'($urandom_range(0, 7));
      bus_if.b1  = 3'($urandom_range(0, 7));
      if (!hold) begin
         bus_if.req0 = 1'b0;
         bus_if.req1 = 1'b0;
      end
      @(negedge clk);
      chk("gnt_pulse", 32'({bus_if.gnt0, bus_if.gnt1}), 32'd0);
      chk("busy_exec", 32'(bus_if.busy), 32'd1);
      chk("done_early", 32'({bus_if.done0, bus_if.done1}), 32'd0);
      @(negedge clk);
      chk("done_owner", 32'({bus_if.done1, bus_if.done0}), (w == 1) ? 32'd2 : 32'd1);
      chk("result", 32'(bus_if.result), 32'(er));
`ifdef ALU_FLAGS_EN
      chk("zero", 32'(bus_if.zero), 32'(er == 0));
      chk("carry", 32'(bus_if.carry), 32'(ref_carry(eop, ea, eb)));
`endif
      if (mode == 1) begin
         if (w == 0) bus_if.ack1 = 1'b1; else bus_if.ack0 = 1'b1;
         @(negedge clk);
         bus_if.ack0 = 1'b0;
         bus_if.ack1 = 1'b0;
         chk("foreign_ack_ignored", 32'({bus_if.done1, bus_if.done0}), (w == 1) ? 32'd2 : 32'd1);
         chk("result_held", 32'(bus_if.result), 32'(er));
         bus_if.req0 = 1'b0;
         bus_if.req1 = 1'b0;
         #2 rst_n = 1'b0;
         #1;
         chk("rst_done", 32'({bus_if.done1, bus_if.done0}), 32'd0);
         chk("rst_busy", 32'(bus_if.busy), 32'd0);
         chk("rst_result", 32'(bus_if.result), 32'd0);
         @(negedge clk);
         rst_n  = 1'b1;
         favour = 0;
      end else begin
         if (w == 0) bus_if.ack0 = 1'b1; else bus_if.ack1 = 1'b1;
         @(negedge clk);
         bus_if.ack0 = 1'b0;
         bus_if.ack1 = 1'b0;
         chk("done_cleared", 32'({bus_if.done1, bus_if.done0}), 32'd0);
         chk("busy_idle", 32'(bus_if.busy), 32'd0);
         favour = 1 - w;
      end
   endtask

   initial begin
      bus_if.req0 = 1'b0; bus_if.op0 = '0; bus_if.a0 = '0; bus_if.b0 = '0;
      bus_if.req1 = 1'b0; bus_if.op1 = '0; bus_if.a1 = '0; bus_if.b1 = '0;
      bus_if.ack0 = 1'b0; bus_if.ack1 = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_gnt", 32'({bus_if.gnt0, bus_if.gnt1}), 32'd0);
      chk("reset_done", 32'({bus_if.done0, bus_if.done1}), 32'd0);
      chk("reset_busy", 32'(bus_if.busy), 32'd0);
      chk("reset_result", 32'(bus_if.result), 32'd0);
      rst_n = 1'b1;
      // Stray acks while idle must not wake anything up.
      bus_if.ack0 = 1'b1;
      bus_if.ack1 = 1'b1;
      repeat (3) @(negedge clk);
      bus_if.ack0 = 1'b0;
      bus_if.ack1 = 1'b0;
      chk("idle_no_gnt", 32'({bus_if.gnt0, bus_if.gnt1}), 32'd0);
      chk("idle_busy", 32'(bus_if.busy), 32'd0);

      txn(1, 0, 0, 3, 6, 0, 0, 0, 0, 0);   // 3+6 mod 8 = 1
      txn(0, 1, 0, 0, 0, 1, 2, 5, 0, 0);   // 2-5 mod 8 = 5
      for (int i = 0; i < 4; i++)
         txn(1, 1, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7), 1, 0);
      txn(1, 0, 2, 6, 3, 0, 0, 0, 0, 0);   // 6&3 = 2
      txn(1, 0, 3, 7, 0, 0, 0, 0, 0, 0);   // 7>>1 = 3
      txn(1, 0, 0, 1, 1, 0, 0, 0, 0, 1);   // foreign ack, then reset in RESP
      txn(1, 1, 1, 4, 4, 2, 5, 5, 0, 0);   // post-reset tie goes to requester 0

      for (int i = 0; i < 40; i++) begin
         int r;
         r = $urandom_range(1, 3);
         txn(r[0], r[1], $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
             1'($urandom_range(0, 1)), 0);
      end
      bus_if.req0 = 1'b0;
      bus_if.req1 = 1'b0;
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
